// File: rtl/cpu_core.sv
// cpu_core: two-stage (fetch / execute) 16-bit word-addressed RISC core.
// Fetch drives iaddr = PC; execute decodes idata one cycle later.
// Loads stall one cycle (load-wait); taken branches/JAL squash one slot.
// Optional macro CPU_MUL_EN: op 9 becomes a single-cycle MUL (else NOP).
module cpu_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] iaddr,
  input  logic [15:0] idata,
  output logic [15:0] waddr,
  output logic [15:0] wdata,
  output logic        we,
  output logic [15:0] raddr,
  input  logic [15:0] rdata,
  output logic        re
);

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] fn;
  } insn_t;

  logic [15:0] pc, ex_pc;
  logic        ex_vld, ld_wait;
  logic [2:0]  ld_rd;
  logic [15:0] rf [8];

  insn_t       ins;
  logic [15:0] ra_v, rb_v, rd_v, imm6, imm9, maddr, alu;
  logic        wr_en, taken, we_c, re_c;
  logic [15:0] wr_val, target;

  assign ins   = insn_t'(idata);
  assign imm6  = {{10{idata[5]}}, idata[5:0]};
  assign imm9  = {{7{idata[8]}}, idata[8:0]};
  assign ra_v  = (ins.ra == 3'd0) ? 16'h0000 : rf[ins.ra];
  assign rb_v  = (ins.rb == 3'd0) ? 16'h0000 : rf[ins.rb];
  assign rd_v  = (ins.rd == 3'd0) ? 16'h0000 : rf[ins.rd];
  assign maddr = ra_v + imm6;

  // register-register ALU selected by fn
  always_comb begin
    alu = 16'h0000;
    case (ins.fn)
      3'd0:    alu = ra_v + rb_v;
      3'd1:    alu = ra_v - rb_v;
      3'd2:    alu = ra_v & rb_v;
      3'd3:    alu = ra_v | rb_v;
      3'd4:    alu = ra_v ^ rb_v;
      3'd5:    alu = ra_v << rb_v[3:0];
      3'd6:    alu = ra_v >> rb_v[3:0];
      3'd7:    alu = ($signed(ra_v) < $signed(rb_v)) ? 16'h0001 : 16'h0000;
      default: alu = 16'h0000;
    endcase
  end

  // execute-stage decode: writeback value, redirect, memory strobes
  always_comb begin
    wr_en  = 1'b0;
    wr_val = 16'h0000;
    taken  = 1'b0;
    target = 16'h0000;
    we_c   = 1'b0;
    re_c   = 1'b0;
    if (ex_vld) begin
      case (ins.op)
        4'd0: begin wr_en = 1'b1; wr_val = alu; end
        4'd1: begin wr_en = 1'b1; wr_val = ra_v + imm6; end
        4'd2: begin wr_en = 1'b1; wr_val = imm9; end
        4'd3: begin wr_en = 1'b1; wr_val = {idata[7:0], rd_v[7:0]}; end
        4'd4: re_c = 1'b1;
        4'd5: we_c = 1'b1;
        4'd6: begin taken = (rd_v == 16'h0000); target = ex_pc + 16'd1 + imm9; end
        4'd7: begin taken = (rd_v != 16'h0000); target = ex_pc + 16'd1 + imm9; end
        // target uses ra_v read before the link lands, so JAL r1,r1 jumps to old r1
        4'd8: begin wr_en = 1'b1; wr_val = ex_pc + 16'd1; taken = 1'b1; target = ra_v; end
`ifdef CPU_MUL_EN
        4'd9: begin wr_en = 1'b1; wr_val = ra_v * rb_v; end
`endif
        default: ;
      endcase
    end
  end

  // outputs are forced quiet while reset is held, even before the first reset edge
  assign iaddr = rst ? pc : RESET_PC;
  assign we    = rst & we_c;
  assign re    = rst & re_c;
  assign waddr = we ? maddr : 16'h0000;
  assign wdata = we ? rd_v  : 16'h0000;
  assign raddr = re ? maddr : 16'h0000;

  // PC / pipeline control: load holds PC once, load-wait resumes fetch, redirect squashes
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc      <= RESET_PC;
      ex_pc   <= RESET_PC;
      ex_vld  <= 1'b0;
      ld_wait <= 1'b0;
      ld_rd   <= 3'd0;
    end else if (ld_wait) begin
      ld_wait <= 1'b0;
      ex_vld  <= 1'b1;
      ex_pc   <= pc;
      pc      <= pc + 16'd1;
    end else if (re_c) begin
      ld_wait <= 1'b1;
      ld_rd   <= ins.rd;
      ex_vld  <= 1'b0;
    end else if (taken) begin
      pc      <= target;
      ex_vld  <= 1'b0;
    end else begin
      ex_vld  <= 1'b1;
      ex_pc   <= pc;
      pc      <= pc + 16'd1;
    end
  end

  // register file: r0 stays zero; load data lands in the load-wait cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
    end else if (ld_wait) begin
      if (ld_rd != 3'd0) rf[ld_rd] <= rdata;
    end else if (wr_en && ins.rd != 3'd0) begin
      rf[ins.rd] <= wr_val;
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: table-driven cycle checks of cpu_core against bench memories.
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] iaddr, idata, waddr, wdata, raddr, rdata;
  logic        we, re;

  int checks = 0;
  int errors = 0;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];

  typedef struct {
    int          cyc;
    logic [15:0] ia;
    logic        w;
    logic [15:0] wa;
    logic [15:0] wd;
    logic        r;
    logic [15:0] ra;
  } vec_t;

  vec_t q[$];

  cpu_core dut (
    .clk(clk), .rst(rst), .iaddr(iaddr), .idata(idata),
    .waddr(waddr), .wdata(wdata), .we(we),
    .raddr(raddr), .rdata(rdata), .re(re)
  );

  always #5 clk = ~clk;

  // instruction memory: synchronous read, always enabled
  always @(posedge clk) idata <= imem[iaddr[7:0]];

  // data memory: registered read, write on we, read-old-data on collision
  always @(posedge clk) begin
    if (!rst) rdata <= 16'h0000;
    else if (re) rdata <= dmem[raddr[7:0]];
    if (we) dmem[waddr[7:0]] <= wdata;
  end

  function automatic logic [15:0] enr(input int op, input int rd, input int ra, input int rb, input int fn);
    return {op[3:0], rd[2:0], ra[2:0], rb[2:0], fn[2:0]};
  endfunction
  function automatic logic [15:0] en6(input int op, input int rd, input int ra, input int imm);
    return {op[3:0], rd[2:0], ra[2:0], imm[5:0]};
  endfunction
  function automatic logic [15:0] en9(input int op, input int rd, input int imm);
    return {op[3:0], rd[2:0], imm[8:0]};
  endfunction
  function automatic vec_t V(input int c, input int ia, input int w, input int wa,
                             input int wd, input int r, input int ra);
    vec_t v;
    v.cyc = c; v.ia = 16'(ia); v.w = w[0]; v.wa = 16'(wa); v.wd = 16'(wd);
    v.r = r[0]; v.ra = 16'(ra);
    return v;
  endfunction

  task automatic chk(input string nm, input int c, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hA000;
  endtask

  // hold reset n cycles, check quiet outputs, release; caller samples cycle 0 next
  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    chk("rst_iaddr_now", -1, iaddr, 16'h0000);
    chk("rst_we_now", -1, {15'd0, we}, 16'h0000);
    chk("rst_re_now", -1, {15'd0, re}, 16'h0000);
    repeat (n) @(negedge clk);
    #1;
    chk("rst_iaddr", -1, iaddr, 16'h0000);
    chk("rst_we", -1, {15'd0, we}, 16'h0000);
    chk("rst_re", -1, {15'd0, re}, 16'h0000);
    chk("rst_waddr", -1, waddr, 16'h0000);
    chk("rst_raddr", -1, raddr, 16'h0000);
    rst = 1'b1;
  endtask

  // walk ncyc cycles after release; table rows fully checked, other cycles must be quiet
  task automatic run(input int ncyc);
    int idx;
    idx = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (idx < q.size() && q[idx].cyc == c) begin
        chk("iaddr", c, iaddr, q[idx].ia);
        chk("we", c, {15'd0, we}, {15'd0, q[idx].w});
        chk("waddr", c, waddr, q[idx].wa);
        chk("wdata", c, wdata, q[idx].wd);
        chk("re", c, {15'd0, re}, {15'd0, q[idx].r});
        chk("raddr", c, raddr, q[idx].ra);
        idx++;
      end else begin
        chk("quiet_we", c, {15'd0, we}, 16'h0000);
        chk("quiet_re", c, {15'd0, re}, 16'h0000);
        chk("quiet_wd", c, wdata, 16'h0000);
      end
    end
    chk("rows_seen", ncyc, 16'(idx), 16'(q.size()));
  endtask

  initial begin
    // ---------------- main program: ALU, store/load, branches, JAL ----------------
    clear_imem();
    imem[0]  = en9(2, 1, 5);          // LI r1,5
    imem[1]  = en9(2, 2, -3);         // LI r2,-3
    imem[2]  = enr(0, 3, 1, 2, 0);    // ADD r3,r1,r2 = 2
    imem[3]  = enr(0, 4, 2, 1, 7);    // SLT r4,r2,r1 = 1
    imem[4]  = enr(0, 5, 1, 1, 5);    // SHL r5,r1,r1 = A0
    imem[5]  = en6(5, 3, 0, 0);       // ST r3,[0]
    imem[6]  = en6(5, 4, 0, 1);       // ST r4,[1]
    imem[7]  = en6(5, 5, 0, 2);       // ST r5,[2]
    imem[8]  = en9(2, 1, 'h42);       // LI r1,42
    imem[9]  = en6(5, 1, 0, 7);       // ST r1,[7]
    imem[10] = en6(4, 2, 0, 7);       // LD r2,[7]
    imem[11] = enr(0, 3, 2, 2, 0);    // ADD r3,r2,r2 = 84
    imem[12] = en6(5, 3, 0, 3);       // ST r3,[3]
    imem[13] = en9(2, 1, 0);          // LI r1,0
    imem[14] = en9(6, 1, 2);          // BZ r1,+2 -> 17
    imem[15] = en6(5, 1, 0, 15);      // squashed
    imem[16] = en6(5, 1, 0, 16);      // skipped
    imem[17] = en9(7, 1, 5);          // BNZ r1 not taken
    imem[18] = en9(2, 2, 'h20);       // LI r2,20
    imem[19] = enr(8, 7, 2, 0, 0);    // JAL r7,r2 -> 20, r7=14
    imem[20] = en6(5, 7, 0, 20);      // squashed
    imem[32] = en6(5, 7, 0, 4);       // ST r7,[4] = 0014
    imem[33] = enr(0, 6, 7, 3, 1);    // SUB r6,r7,r3 = FF90
    imem[34] = en6(5, 6, 0, 5);       // ST r6,[5]
    imem[35] = en9(2, 1, 'hF3);       // LI r1,F3
    imem[36] = en9(3, 1, 'h5A);       // LUI r1 -> 5AF3
    imem[37] = en9(2, 2, 'h1F0);      // LI r2 -> FFF0
    imem[38] = enr(0, 3, 1, 2, 2);    // AND = 5AF0
    imem[39] = enr(0, 4, 1, 2, 3);    // OR  = FFF3
    imem[40] = enr(0, 5, 1, 2, 4);    // XOR = A503
    imem[41] = en6(5, 3, 0, 8);
    imem[42] = en6(5, 4, 0, 9);
    imem[43] = en6(5, 5, 0, 10);
    imem[44] = en9(2, 6, 4);          // LI r6,4
    imem[45] = enr(0, 3, 2, 6, 6);    // SHR r3,r2,r6 = 0FFF
    imem[46] = en6(1, 4, 3, -2);      // ADDI r4,r3,-2 = 0FFD
    imem[47] = enr(0, 5, 1, 2, 7);    // SLT 5AF3 < FFF0 signed -> 0
    imem[48] = en6(5, 3, 0, 11);
    imem[49] = en6(5, 4, 0, 12);
    imem[50] = en6(5, 5, 0, 13);
    imem[51] = en9(6, 0, -1);         // BZ r0,-1 (spin)

    q.delete();
    q.push_back(V(0, 0, 0, 0, 0, 0, 0));
    q.push_back(V(1, 1, 0, 0, 0, 0, 0));
    q.push_back(V(2, 2, 0, 0, 0, 0, 0));
    q.push_back(V(6, 6, 1, 0, 'h0002, 0, 0));
    q.push_back(V(7, 7, 1, 1, 'h0001, 0, 0));
    q.push_back(V(8, 8, 1, 2, 'h00A0, 0, 0));
    q.push_back(V(10, 10, 1, 7, 'h0042, 0, 0));
    q.push_back(V(11, 11, 0, 0, 0, 1, 7));
    q.push_back(V(12, 11, 0, 0, 0, 0, 0));
    q.push_back(V(13, 12, 0, 0, 0, 0, 0));
    q.push_back(V(14, 13, 1, 3, 'h0084, 0, 0));
    q.push_back(V(16, 15, 0, 0, 0, 0, 0));
    q.push_back(V(17, 17, 0, 0, 0, 0, 0));
    q.push_back(V(18, 18, 0, 0, 0, 0, 0));
    q.push_back(V(20, 20, 0, 0, 0, 0, 0));
    q.push_back(V(21, 'h20, 0, 0, 0, 0, 0));
    q.push_back(V(22, 'h21, 1, 4, 'h0014, 0, 0));
    q.push_back(V(24, 'h23, 1, 5, 'hFF90, 0, 0));
    q.push_back(V(31, 42, 1, 8, 'h5AF0, 0, 0));
    q.push_back(V(32, 43, 1, 9, 'hFFF3, 0, 0));
    q.push_back(V(33, 44, 1, 10, 'hA503, 0, 0));
    q.push_back(V(38, 49, 1, 11, 'h0FFF, 0, 0));
    q.push_back(V(39, 50, 1, 12, 'h0FFD, 0, 0));
    q.push_back(V(40, 51, 1, 13, 'h0000, 0, 0));
    q.push_back(V(41, 52, 0, 0, 0, 0, 0));
    q.push_back(V(42, 51, 0, 0, 0, 0, 0));
    q.push_back(V(43, 52, 0, 0, 0, 0, 0));
    do_reset(2);
    run(46);

    // ---------------- load then JAL r1,r1 (target = old r1) ----------------
    clear_imem();
    imem[0] = en9(2, 1, 4);           // LI r1,4
    imem[1] = en6(4, 2, 0, 3);        // LD r2,[3] (holds 0084)
    imem[2] = enr(8, 1, 1, 0, 0);     // JAL r1,r1 -> 4, r1=3
    imem[3] = en6(5, 0, 0, 30);       // squashed
    imem[4] = en6(5, 1, 0, 21);       // ST r1,[21] = 0003
    imem[5] = en6(5, 2, 0, 22);       // ST r2,[22] = 0084
    imem[6] = en9(6, 0, -1);
    q.delete();
    q.push_back(V(0, 0, 0, 0, 0, 0, 0));
    q.push_back(V(1, 1, 0, 0, 0, 0, 0));
    q.push_back(V(2, 2, 0, 0, 0, 1, 3));
    q.push_back(V(3, 2, 0, 0, 0, 0, 0));
    q.push_back(V(4, 3, 0, 0, 0, 0, 0));
    q.push_back(V(5, 4, 0, 0, 0, 0, 0));
    q.push_back(V(6, 5, 1, 21, 'h0003, 0, 0));
    q.push_back(V(7, 6, 1, 22, 'h0084, 0, 0));
    do_reset(2);
    run(9);

    // reset during the load-wait cycle: outputs drop at once, then clean restart
    do_reset(2);
    repeat (3) @(negedge clk);
    #1;
    chk("midload_iaddr", 3, iaddr, 16'h0002);
    do_reset(2);
    run(9);

    // ---------------- op 9 (MUL or NOP by build) and op 10 NOP ----------------
    clear_imem();
    imem[0] = en9(2, 1, 0);
    imem[1] = en9(3, 1, 1);           // r1 = 0100
    imem[2] = en9(2, 2, 1);
    imem[3] = en9(3, 2, 1);           // r2 = 0101
    imem[4] = en9(2, 3, 7);           // r3 = 0007
    imem[5] = enr(9, 3, 1, 2, 0);     // MUL r3,r1,r2
    imem[6] = enr(10, 3, 1, 2, 0);    // NOP
    imem[7] = en6(5, 3, 0, 0);        // ST r3,[0]
    imem[8] = en9(6, 0, -1);
    q.delete();
    q.push_back(V(0, 0, 0, 0, 0, 0, 0));
`ifdef CPU_MUL_EN
    q.push_back(V(8, 8, 1, 0, 'h0100, 0, 0));
`else
    q.push_back(V(8, 8, 1, 0, 'h0007, 0, 0));
`endif
    do_reset(2);
    run(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
# cpu_core

Two-stage (fetch / execute) 16-bit word-addressed RISC core with separate instruction and data memory ports. Sits between a synchronous-read instruction memory (read-enable tied high, never written) and a synchronous-read/write data memory; owns the PC, an 8-entry register file and the ALU. The memory contract is specified under Timing.

## Interface
- RESET_PC, 16'h0000, PC value loaded while reset is asserted.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset asserted).
- iaddr  out  16  instruction fetch address (= PC).
- idata  in  16  instruction word, valid one cycle after iaddr.
- waddr  out  16  data store address.
- wdata  out  16  data store value.
- we  out  1  store strobe, one cycle per store.
- raddr  out  16  data load address.
- rdata  in  16  load data, valid one cycle after raddr/re.
- re  out  1  load strobe.

## Operation
- Format: op[15:12], rd[11:9], ra[8:6], rb[5:3], fn[2:0]; imm6 = [5:0], imm9 = [8:0], both sign-extended.
- r0 reads 0; writes to r0 discarded. r1..r7 general purpose. All arithmetic 16-bit, wrap-around, no flags.
- op 0 ALU, by fn: 0 add, 1 sub (ra-rb), 2 and, 3 or, 4 xor, 5 shl (ra << rb[3:0]), 6 shr logical, 7 slt signed (1/0).
- op 1 ADDI: rd = ra + imm6. op 2 LI: rd = imm9. op 3 LUI: rd = {[7:0], rd[7:0]}.
- op 4 LD: rd = dmem[ra + imm6]. op 5 ST: dmem[ra + imm6] = rd.
- op 6 BZ: if rd == 0, PC = A + 1 + imm9 (A = branch's own address). op 7 BNZ: same if rd != 0.
- op 8 JAL: rd = A + 1; PC = ra (link written after ra is read, so JAL r1,r1 jumps to old r1).
- op 9: see Configuration. ops 10..15: NOP.

## Timing
- Reset: PC = RESET_PC, r1..r7 = 0, execute-valid = 0, load-wait = 0. Outputs during reset: iaddr = RESET_PC, we = re = 0, waddr = wdata = raddr = 0.
- Fetch: iaddr = PC combinationally. Execute consumes idata the following cycle. First instruction executes in the second cycle after rst goes high.
- Normal cycle: PC <= PC + 1; execute result written on the same edge.
- Store: we = 1, waddr/wdata driven combinationally in the execute cycle; memory writes on that edge.
- Load (1 stall): cycle 1 drives re = 1, raddr; PC held. Cycle 2 (load-wait): rd <= rdata, idata ignored, PC held. Cycle 3 executes the instruction following the load normally. Back-to-back dependent loads therefore need no forwarding.
- Taken branch/JAL: PC <= target; the instruction arriving next cycle is squashed (valid = 0); 1 bubble. Not-taken: no penalty.
- Invalid/squashed/load-wait cycles: we = re = 0, no register write, address/data outputs 0.
- Reset asserted mid-load or mid-branch: abandons the operation; no write from rdata.
- Memory contract: read registered (rdata <= mem[raddr] on edge when re, else hold), write on edge when we, rdata = 0 under reset; read-during-write to the same address returns old data.

## Configuration
- CPU_MUL_EN defined: op 9 MUL, rd = low 16 bits of ra * rb (unsigned), single cycle.
- Not defined: op 9 is a NOP; no multiplier is synthesized.

## Test plan
- Reset: hold rst = 0 for 2 cycles -> iaddr = 0000, we = re = 0; release -> iaddr 0000, 0001, 0002 on successive cycles.
- ALU: LI r1,5; LI r2,-3; ADD r3,r1,r2; SLT r4,r2,r1; SHL r5,r1,r1 -> r3 = 0002, r4 = 0001, r5 = 00A0.
- Memory: LI r1,0x42; ST r1,[r0+7]; LD r2,[r0+7]; ADD r3,r2,r2 -> we with waddr 0007/wdata 0042; re with raddr 0007; PC held 1 cycle; r3 = 0084.
- Branch: LI r1,0; BZ r1,+2 at A=3 -> next executed address 6; instruction at 4 squashed (no we/re, no write). BNZ r1 not taken -> no bubble.
- JAL: LI r2,0x10; JAL r7,r2 at A=5 -> r7 = 0006, iaddr = 0010 next cycle.
- MUL: r1 = 0x0100, r2 = 0x0101, op 9 -> r3 = 0x0100 with CPU_MUL_EN; r3 unchanged without it.
